// File: rtl/cp0_exc_ctrl_if.sv
// mfc0/mtc0 access bus between the datapath (master) and the CP0 block (slave).
interface cp0_exc_ctrl_if;
    logic        cp0_we;
    logic [4:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;

    modport master (output cp0_we, cp0_sel, cp0_wdata, input cp0_rdata);
    modport slave  (input cp0_we, cp0_sel, cp0_wdata, output cp0_rdata);
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId, boundary decision and eret.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter logic [31:0] PRID       = 32'h2019_0300
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         hw_int,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic               insn_done,
    input  logic [31:0]        pc_cur,
    input  logic               eret,
    cp0_exc_ctrl_if.slave      bus,
    output logic               take_exc,
    output logic [31:0]        exc_pc,
    output logic               exl
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TAKE = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic [29:0] epc_q, epc_d;

    logic wr_sr, wr_epc, irq_pend, boundary, entry, timer_ip;
    logic unused_pc;

    assign unused_pc = ^pc_cur[1:0];
    assign wr_sr     = bus.cp0_we && (bus.cp0_sel == 5'd12);
    assign wr_epc    = bus.cp0_we && (bus.cp0_sel == 5'd14);

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        hit_q, hit_d;
    logic        wr_count, wr_compare;

    assign wr_count   = bus.cp0_we && (bus.cp0_sel == 5'd9);
    assign wr_compare = bus.cp0_we && (bus.cp0_sel == 5'd11);
    assign timer_ip   = hit_q;

    always_comb begin
        count_d   = wr_count ? bus.cp0_wdata : count_q + 32'd1;
        compare_d = wr_compare ? bus.cp0_wdata : compare_q;
        // Compare==0 means the timer is disarmed; writing Compare acknowledges the hit
        hit_d     = wr_compare ? 1'b0
                  : (hit_q | ((count_q == compare_q) && (compare_q != 32'd0)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            hit_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            hit_q     <= hit_d;
        end
    end
`else
    assign timer_ip = 1'b0;
`endif

    always_comb begin
        ip_d     = {hw_int[5] | timer_ip, hw_int[4:0]};
        irq_pend = (|(ip_q & im_q)) & ie_q & ~exl_q;
        boundary = (state_q == S_IDLE) & insn_done;
        // eret boundary never enters, so the returning instruction is not re-interrupted
        entry    = boundary & ~eret & ~exl_q & (exc_req | irq_pend);

        im_d   = im_q;
        ie_d   = ie_q;
        exl_d  = exl_q;
        epc_d  = epc_q;
        code_d = code_q;

        if (wr_sr) begin
            im_d  = bus.cp0_wdata[15:10];
            exl_d = bus.cp0_wdata[1];
            ie_d  = bus.cp0_wdata[0];
        end
        if (wr_epc)
            epc_d = bus.cp0_wdata[31:2];
        if (boundary && eret)
            exl_d = 1'b0;
        if (entry) begin
            epc_d  = pc_cur[31:2];
            exl_d  = 1'b1;
            code_d = exc_req ? exc_code : 5'd0;
        end
        state_d = entry ? S_TAKE : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            im_q    <= 6'd0;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            ip_q    <= 6'd0;
            code_q  <= 5'd0;
            epc_q   <= 30'd0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            ip_q    <= ip_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
        end
    end

    assign take_exc = (state_q == S_TAKE);
    assign exc_pc   = take_exc ? EXC_VECTOR : {epc_q, 2'b00};
    assign exl      = exl_q;

    always_comb begin
        case (bus.cp0_sel)
            5'd12:   bus.cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   bus.cp0_rdata = {16'd0, ip_q, 3'd0, code_q, 2'd0};
            5'd14:   bus.cp0_rdata = {epc_q, 2'b00};
            5'd15:   bus.cp0_rdata = PRID;
`ifdef CP0_TIMER_EN
            5'd9:    bus.cp0_rdata = count_q;
            5'd11:   bus.cp0_rdata = compare_q;
`endif
            default: bus.cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: register-level model checked every cycle plus literal spot checks.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC  = 32'h0000_0180;
    localparam logic [31:0] PRID = 32'h2019_0300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  hw_int = '0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic        insn_done = 1'b0;
    logic [31:0] pc_cur = '0;
    logic        eret = 1'b0;
    logic        take_exc, exl;
    logic [31:0] exc_pc;

    cp0_exc_ctrl_if bus();

    cp0_exc_ctrl dut (
        .clk(clk), .rst(rst), .hw_int(hw_int), .exc_req(exc_req), .exc_code(exc_code),
        .insn_done(insn_done), .pc_cur(pc_cur), .eret(eret), .bus(bus),
        .take_exc(take_exc), .exc_pc(exc_pc), .exl(exl)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state held as whole architectural register values
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_cmp;
    logic        m_take, m_hit;

    task automatic model_reset();
        m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_cmp = 0;
        m_take = 0; m_hit = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] sel);
        case (sel)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("take_exc", {31'd0, take_exc}, {31'd0, m_take});
        chk("exc_pc", exc_pc, m_take ? VEC : m_epc);
        chk("exl", {31'd0, exl}, {31'd0, m_sr[1]});
        chk("cp0_rdata", bus.cp0_rdata, exp_read(bus.cp0_sel));
    endtask

    // One clock: evaluate the rules on pre-edge inputs, advance, then compare at negedge
    task automatic cyc();
        logic [31:0] n_sr, n_epc, n_cause, n_count, n_cmp;
        logic [5:0]  ip, im, hw;
        logic [4:0]  code;
        logic        irq, bnd, go, n_hit;
        ip  = m_cause[15:10];
        im  = m_sr[15:10];
        irq = (|(ip & im)) && m_sr[0] && !m_sr[1];
        bnd = insn_done && !m_take;
        go  = bnd && !eret && !m_sr[1] && (exc_req || irq);
        n_sr = m_sr; n_epc = m_epc; code = m_cause[6:2];
        if (bus.cp0_we && bus.cp0_sel == 5'd12) n_sr = bus.cp0_wdata & 32'h0000_FC03;
        if (bus.cp0_we && bus.cp0_sel == 5'd14) n_epc = bus.cp0_wdata & ~32'h3;
        if (bnd && eret) n_sr[1] = 1'b0;
        if (go) begin
            n_epc = pc_cur; n_sr[1] = 1'b1; code = exc_req ? exc_code : 5'd0;
        end
        n_count = m_count; n_cmp = m_cmp; n_hit = m_hit; hw = hw_int;
`ifdef CP0_TIMER_EN
        n_count = (bus.cp0_we && bus.cp0_sel == 5'd9) ? bus.cp0_wdata : m_count + 1;
        n_cmp   = (bus.cp0_we && bus.cp0_sel == 5'd11) ? bus.cp0_wdata : m_cmp;
        n_hit   = (bus.cp0_we && bus.cp0_sel == 5'd11) ? 1'b0
                : (m_hit || (m_count == m_cmp && m_cmp != 0));
        hw[5]   = hw_int[5] | m_hit;
`endif
        n_cause = ({26'd0, hw} << 10) | ({27'd0, code} << 2);
        @(posedge clk);
        if (rst) begin
            m_sr = n_sr; m_epc = n_epc; m_cause = n_cause; m_take = go;
            m_count = n_count; m_cmp = n_cmp; m_hit = n_hit;
        end else model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic peek(input string name, input logic [4:0] sel, input logic [31:0] exp);
        bus.cp0_sel = sel;
        #1;
        chk(name, bus.cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] sel, input logic [31:0] d);
        bus.cp0_we = 1; bus.cp0_sel = sel; bus.cp0_wdata = d;
        cyc();
        bus.cp0_we = 0;
    endtask

    task automatic boundary(input logic er, input logic xr, input logic [4:0] xc, input logic [31:0] pc);
        insn_done = 1; eret = er; exc_req = xr; exc_code = xc; pc_cur = pc;
        cyc();
        insn_done = 0; eret = 0; exc_req = 0;
    endtask

    initial begin
        bus.cp0_we = 0; bus.cp0_sel = 5'd12; bus.cp0_wdata = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        rst = 1;
        cyc();

        // Reset clears a pre-written SR asynchronously
        mtc0(5'd12, 32'h0000_FC01);
        rst = 0; #1;
        model_reset();
        chk("rst_take", {31'd0, take_exc}, 32'd0);
        chk("rst_exl", {31'd0, exl}, 32'd0);
        peek("rst_sr", 5'd12, 32'd0);
        peek("rst_cause", 5'd13, 32'd0);
        peek("rst_epc", 5'd14, 32'd0);
        cyc();
        rst = 1;
        cyc();

        // Interrupt entry on IP[10]
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        cyc();
        boundary(0, 0, 5'd0, 32'h0000_3008);
        chk("irq_take", {31'd0, take_exc}, 32'd1);
        chk("irq_vec", exc_pc, 32'h0000_0180);
        chk("irq_exl", {31'd0, exl}, 32'd1);
        cyc();
        chk("pulse_one", {31'd0, take_exc}, 32'd0);
        peek("irq_epc", 5'd14, 32'h0000_3008);
        peek("irq_cause", 5'd13, 32'h0000_0400);

        // No nesting while EXL=1
        boundary(0, 1, 5'd10, 32'h0000_4000);
        chk("nest_take", {31'd0, take_exc}, 32'd0);
        peek("nest_epc", 5'd14, 32'h0000_3008);

        // eret exposes EPC in the same cycle, pending IRQ taken at the next boundary
        insn_done = 1; eret = 1; #1;
        chk("eret_pc", exc_pc, 32'h0000_3008);
        boundary(1, 0, 5'd0, 32'h0000_3008);
        chk("eret_exl", {31'd0, exl}, 32'd0);
        chk("eret_nopulse", {31'd0, take_exc}, 32'd0);
        boundary(0, 0, 5'd0, 32'h0000_300C);
        chk("pend_take", {31'd0, take_exc}, 32'd1);
        cyc();
        peek("pend_epc", 5'd14, 32'h0000_300C);

        // Exception beats interrupt at the same boundary
        boundary(1, 0, 5'd0, 32'h0);
        boundary(0, 1, 5'd12, 32'h0000_3020);
        chk("ov_take", {31'd0, take_exc}, 32'd1);
        cyc();
        chk("ov_single", {31'd0, take_exc}, 32'd0);
        peek("ov_cause", 5'd13, 32'h0000_0430);

        // Entry wins over mtc0 EPC on the same edge
        hw_int = 0;
        boundary(1, 0, 5'd0, 32'h0);
        cyc();
        bus.cp0_we = 1; bus.cp0_sel = 5'd14; bus.cp0_wdata = 32'h0000_1234;
        boundary(0, 1, 5'd4, 32'h0000_3010);
        bus.cp0_we = 0;
        cyc();
        peek("mtc0_epc", 5'd14, 32'h0000_3010);
        peek("mtc0_cause", 5'd13, 32'h0000_0010);

        // PRId, unimplemented registers
        boundary(1, 0, 5'd0, 32'h0);
        peek("prid", 5'd15, 32'h2019_0300);
        mtc0(5'd3, 32'hFFFF_FFFF);
        peek("sel3", 5'd3, 32'd0);
`ifndef CP0_TIMER_EN
        peek("sel9", 5'd9, 32'd0);
        peek("sel11", 5'd11, 32'd0);
`endif

        // Reset during the TAKE pulse aborts it immediately
        bus.cp0_sel = 5'd12;
        insn_done = 1; exc_req = 1; exc_code = 5'd5; pc_cur = 32'h0000_3040;
        @(posedge clk); #2;
        chk("pre_rst_take", {31'd0, take_exc}, 32'd1);
        rst = 0; #1;
        chk("midtake_rst", {31'd0, take_exc}, 32'd0);
        model_reset();
        insn_done = 0; exc_req = 0;
        @(negedge clk);
        check_all();
        rst = 1;
        cyc();

`ifdef CP0_TIMER_EN
        begin
            int budget;
            mtc0(5'd11, 32'd20);
            mtc0(5'd12, 32'h0000_8001);
            insn_done = 1;
            budget = 0;
            while (!take_exc && budget < 60) begin cyc(); budget++; end
            chk("timer_taken", {31'd0, take_exc}, 32'd1);
            insn_done = 0;
            peek("timer_ip15", 5'd13, 32'h0000_8000);
            mtc0(5'd11, 32'd0);
            cyc();
            peek("timer_clr", 5'd13, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
